cov_matrix_accum: RTL and testbench



---
 rtl/cov_matrix_accum.sv | 178 +++++++++++++++++
 tb/tb_cov_matrix_accum.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cov_matrix_accum.sv
// Sample covariance accumulator: N_SNAP 4-channel snapshots, one shared MAC over the
// upper triangle, scaled by 1/N_SNAP and presented as a symmetric 4x4 matrix.
module cov_matrix_accum #(
    parameter int N_SNAP = 64,
    parameter int LOG2_N = 6,
    parameter int IN_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   x_valid,
    output logic                   x_ready,
    input  logic signed [IN_W-1:0] x0,
    input  logic signed [IN_W-1:0] x1,
    input  logic signed [IN_W-1:0] x2,
    input  logic signed [IN_W-1:0] x3,
    input  logic                   evd_done,
    output logic                   data_available,
    output logic signed [31:0]     A0,
    output logic signed [31:0]     A1,
    output logic signed [31:0]     A2,
    output logic signed [31:0]     A3,
    output logic signed [31:0]     A4,
    output logic signed [31:0]     A5,
    output logic signed [31:0]     A6,
    output logic signed [31:0]     A7,
    output logic signed [31:0]     A8,
    output logic signed [31:0]     A9,
    output logic signed [31:0]     A10,
    output logic signed [31:0]     A11,
    output logic signed [31:0]     A12,
    output logic signed [31:0]     A13,
    output logic signed [31:0]     A14,
    output logic signed [31:0]     A15
);
    localparam int ACC_W = 2 * IN_W + LOG2_N;
    localparam int CNT_W = LOG2_N + 1;
    localparam int N_ACC = 10;

    typedef enum logic [1:0] {S_COLLECT, S_MAC, S_SCALE, S_HOLD} state_t;

    // Upper-triangle pair (i,j), i<=j, to accumulator index in MAC order.
    function automatic int tri_idx(input int i, input int j);
        return i * 4 - (i * (i - 1)) / 2 + (j - i);
    endfunction

    state_t                    r_state;
    state_t                    w_state_next;
    logic [3:0]                r_step;
    logic [CNT_W-1:0]          r_cnt;
    logic signed [IN_W-1:0]    r_x [4];
    logic signed [ACC_W-1:0]   r_acc [N_ACC];
    logic signed [31:0]        r_a [16];
    logic signed [31:0]        w_scaled [N_ACC];
    logic signed [31:0]        w_full [16];
    logic signed [IN_W-1:0]    w_opa;
    logic signed [IN_W-1:0]    w_opb;
    logic signed [2*IN_W-1:0]  w_prod;
    logic                      w_accept;
    logic                      w_release;
    logic                      w_frame_full;

    assign w_accept     = (r_state == S_COLLECT) && x_valid;
    assign w_release    = (r_state == S_HOLD) && evd_done;
    assign w_frame_full = (r_cnt == CNT_W'(N_SNAP));

    always_comb begin
        w_state_next   = r_state;
        x_ready        = 1'b0;
        data_available = 1'b0;
        case (r_state)
            S_COLLECT: begin
                x_ready = 1'b1;
                if (x_valid) w_state_next = S_MAC;
            end
            S_MAC: begin
                if (r_step == 4'd9) w_state_next = w_frame_full ? S_SCALE : S_COLLECT;
            end
            S_SCALE: w_state_next = S_HOLD;
            S_HOLD: begin
                data_available = 1'b1;
                if (evd_done) w_state_next = S_COLLECT;
            end
            default: w_state_next = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_COLLECT;
            r_step  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_cnt  <= r_cnt + CNT_W'(1);
                r_step <= '0;
            end else if (r_state == S_MAC) begin
                r_step <= r_step + 4'd1;
            end
            if (w_release) r_cnt <= '0;
        end
    end

    // Snapshot registers only load on acceptance; their contents are don't-care otherwise.
    always_ff @(posedge clk) begin
        if (w_accept) r_x <= '{x0, x1, x2, x3};
    end

    always_comb begin
        w_opa = r_x[3];
        w_opb = r_x[3];
        case (r_step)
            4'd0: begin w_opa = r_x[0]; w_opb = r_x[0]; end
            4'd1: begin w_opa = r_x[0]; w_opb = r_x[1]; end
            4'd2: begin w_opa = r_x[0]; w_opb = r_x[2]; end
            4'd3: begin w_opa = r_x[0]; w_opb = r_x[3]; end
            4'd4: begin w_opa = r_x[1]; w_opb = r_x[1]; end
            4'd5: begin w_opa = r_x[1]; w_opb = r_x[2]; end
            4'd6: begin w_opa = r_x[1]; w_opb = r_x[3]; end
            4'd7: begin w_opa = r_x[2]; w_opb = r_x[2]; end
            4'd8: begin w_opa = r_x[2]; w_opb = r_x[3]; end
            default: begin w_opa = r_x[3]; w_opb = r_x[3]; end
        endcase
    end

    assign w_prod = (2*IN_W)'(w_opa) * (2*IN_W)'(w_opb);

    always_ff @(posedge clk) begin
        if (rst || w_release) begin
            for (int p = 0; p < N_ACC; p++) r_acc[p] <= '0;
        end else if (r_state == S_MAC) begin
            for (int p = 0; p < N_ACC; p++) begin
                if (r_step == 4'(p)) r_acc[p] <= r_acc[p] + ACC_W'(w_prod);
            end
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < N_ACC; gi++) begin : g_scale
            // Arithmetic shift floors toward -inf; the result always fits 32 bits signed.
            assign w_scaled[gi] = 32'(r_acc[gi] >>> LOG2_N);
        end
        for (gi = 0; gi < 4; gi++) begin : g_row
            for (gj = 0; gj < 4; gj++) begin : g_col
                localparam int P = (gi <= gj) ? tri_idx(gi, gj) : tri_idx(gj, gi);
                assign w_full[4*gi+gj] = w_scaled[P];
            end
        end
    endgenerate

    // Outputs load only in S_SCALE, so they survive S_HOLD and the following frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 16; k++) r_a[k] <= '0;
        end else if (r_state == S_SCALE) begin
            for (int k = 0; k < 16; k++) r_a[k] <= w_full[k];
        end
    end

    assign A0  = r_a[0];
    assign A1  = r_a[1];
    assign A2  = r_a[2];
    assign A3  = r_a[3];
    assign A4  = r_a[4];
    assign A5  = r_a[5];
    assign A6  = r_a[6];
    assign A7  = r_a[7];
    assign A8  = r_a[8];
    assign A9  = r_a[9];
    assign A10 = r_a[10];
    assign A11 = r_a[11];
    assign A12 = r_a[12];
    assign A13 = r_a[13];
    assign A14 = r_a[14];
    assign A15 = r_a[15];

endmodule

// File: tb/tb_cov_matrix_accum.sv
// Randomized bench for cov_matrix_accum against a frame-level covariance model
// with cycle-accurate handshake expectations.
module tb_cov_matrix_accum;
    localparam int N    = 4;
    localparam int LOG2 = 2;

    logic clk;
    logic rst;
    logic x_valid;
    logic x_ready;
    logic signed [15:0] x0, x1, x2, x3;
    logic evd_done;
    logic data_available;
    logic signed [31:0] a_out [16];

    cov_matrix_accum #(.N_SNAP(N), .LOG2_N(LOG2), .IN_W(16)) dut (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x_ready(x_ready),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3),
        .evd_done(evd_done), .data_available(data_available),
        .A0(a_out[0]),   .A1(a_out[1]),   .A2(a_out[2]),   .A3(a_out[3]),
        .A4(a_out[4]),   .A5(a_out[5]),   .A6(a_out[6]),   .A7(a_out[7]),
        .A8(a_out[8]),   .A9(a_out[9]),   .A10(a_out[10]), .A11(a_out[11]),
        .A12(a_out[12]), .A13(a_out[13]), .A14(a_out[14]), .A15(a_out[15])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: frame sums of x*x^T plus the expected handshake timeline.
    longint m_s [4][4];
    int     m_a [16];
    int     m_cnt;
    int     m_busy;
    bit     m_scale;
    bit     m_hold;
    bit     m_acc;
    int     n_edges = 0;

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d (edge %0d)", tag, got, exp, n_edges);
        end
    endtask

    task automatic clear_sums();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) m_s[i][j] = 0;
        m_cnt = 0;
    endtask

    task automatic model_reset();
        clear_sums();
        for (int k = 0; k < 16; k++) m_a[k] = 0;
        m_busy = 0; m_scale = 0; m_hold = 0; m_acc = 0;
    endtask

    // Check outputs against the model, clock one edge, advance the model.
    task automatic step();
        logic exp_ready;
        longint xv [4];
        exp_ready = (m_busy == 0) && !m_scale && !m_hold;
        chk("x_ready", x_ready, exp_ready);
        chk("data_available", data_available, m_hold);
        for (int k = 0; k < 16; k++) chk($sformatf("A%0d", k), a_out[k], m_a[k]);
        m_acc = !rst && x_valid && exp_ready;
        xv[0] = x0; xv[1] = x1; xv[2] = x2; xv[3] = x3;
        @(posedge clk);
        n_edges++;
        if (rst) begin
            model_reset();
        end else if (m_hold) begin
            if (evd_done) begin
                m_hold = 0;
                clear_sums();
            end
        end else if (m_scale) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) m_a[4*i+j] = int'(m_s[i][j] >>> LOG2);
            m_scale = 0;
            m_hold  = 1;
        end else if (m_acc) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) m_s[i][j] += xv[i] * xv[j];
            m_cnt++;
            m_busy = 10;
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0 && m_cnt == N) m_scale = 1;
        end
        #1;
    endtask

    task automatic send(input logic signed [15:0] a, input logic signed [15:0] b,
                        input logic signed [15:0] c, input logic signed [15:0] d);
        x_valid = 1'b1; x0 = a; x1 = b; x2 = c; x3 = d;
        for (int t = 0; t < 40; t++) begin
            step();
            if (m_acc) break;
        end
        x_valid = 1'b0;
    endtask

    task automatic run_to_hold();
        for (int t = 0; t < 200; t++) begin
            if (m_hold) break;
            step();
        end
    endtask

    task automatic release_hold();
        evd_done = 1'b1;
        step();
        evd_done = 1'b0;
        step();
    endtask

    function automatic logic signed [15:0] rnd_sample();
        case ($urandom % 4)
            0: return -16'sd32768;
            1: return 16'sd32767;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_edge;
        int seen;
        rst = 1'b1; x_valid = 1'b0; evd_done = 1'b0;
        x0 = '0; x1 = '0; x2 = '0; x3 = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        step();

        // Scaling and latency: first acceptance to data_available is 11*N edges.
        send(16'sd100, 16'sd0, 16'sd0, 16'sd0);
        first_edge = n_edges;
        for (int s = 1; s < N; s++) send(16'sd100, 16'sd0, 16'sd0, 16'sd0);
        for (int t = 0; t < 100; t++) begin
            if (data_available === 1'b1) break;
            step();
        end
        chk("latency", n_edges - first_edge, 11 * N);
        chk("scale_A0", a_out[0], 10000);
        chk("scale_A5", a_out[5], 0);
        for (int t = 0; t < 100; t++) step();
        release_hold();

        // Symmetry, plus evd_done pulsed while collecting has no effect.
        evd_done = 1'b1; step(); evd_done = 1'b0; step();
        for (int s = 0; s < N; s++) send(16'sd1, 16'sd2, 16'sd3, 16'sd4);
        run_to_hold();
        chk("sym_A1", a_out[1], 2);
        chk("sym_A4", a_out[4], 2);
        chk("sym_A11", a_out[11], 12);
        chk("sym_A14", a_out[14], 12);
        chk("sym_A15", a_out[15], 16);
        release_hold();

        // Extreme values.
        for (int s = 0; s < N / 2; s++) begin
            send(-16'sd32768, 16'sd32767, -16'sd32768, 16'sd32767);
            send(16'sd32767, -16'sd32768, 16'sd32767, -16'sd32768);
        end
        run_to_hold();
        chk("ext_A0", a_out[0], 1073709056);
        chk("ext_A1", a_out[1], -1073709056);
        release_hold();

        // Backpressure: x_valid held high with changing data for 30 cycles.
        seen = 0;
        x_valid = 1'b1;
        for (int t = 0; t < 30; t++) begin
            x0 = rnd_sample(); x1 = rnd_sample(); x2 = rnd_sample(); x3 = rnd_sample();
            if (x_ready === 1'b1) seen++;
            step();
        end
        x_valid = 1'b0;
        chk("bp_accepts", seen, 3);
        for (int t = 0; t < 12; t++) step();
        send(rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample());
        run_to_hold();
        release_hold();

        // Reset mid-frame discards partial sums and clears the outputs.
        for (int s = 0; s < 2; s++) send(rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample());
        step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_A0", a_out[0], 0);
        chk("rst_da", data_available, 0);
        for (int s = 0; s < N; s++) send(rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample());
        run_to_hold();
        for (int t = 0; t < 5; t++) step();
        release_hold();

        // Random traffic: sparse valid, random evd_done, occasional resets.
        for (int t = 0; t < 2000; t++) begin
            x_valid  = ($urandom % 3) != 0;
            x0 = rnd_sample(); x1 = rnd_sample(); x2 = rnd_sample(); x3 = rnd_sample();
            evd_done = ($urandom % 6) == 0;
            rst      = ($urandom % 500) == 0;
            step();
        end
        rst = 1'b0; x_valid = 1'b0; evd_done = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
